// File: rtl/display_datapath.sv
// Note-highway draw datapath: scrolling 8x4 note grid, box origin/pixel address latches, VGA plot strobes.
// Optional HIT_LINE_EN macro: empty cells in grid row 6 draw white to highlight the strum line.
module display_datapath #(
    parameter int unsigned LANE_X0   = 24,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        loadDefault,
    input  logic        writeDefault,
    input  logic        loadStartAddress,
    input  logic        loadX,
    input  logic        loadY,
    input  logic        writeToScreen,
    input  logic        shiftSong,
    input  logic [15:0] gridCounter,
    input  logic [1:0]  boxCounter,
    input  logic [15:0] pixelCount,
    input  logic [3:0]  noteIn,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic [3:0]  hitRow
);

    localparam int unsigned ROWS     = 8;
    localparam int unsigned LANES    = 4;
    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned HIT_ROW  = 6;

    logic [LANES-1:0] grid [ROWS];
    logic [7:0]       base_x;
    logic [6:0]       base_y;
    logic [2:0]       cell_colour;
    logic             cell_offscreen;

    logic [2:0] row_sel;
    logic       cell_bit;
    logic [2:0] lane_colour;
    logic [2:0] empty_colour;
    logic [2:0] next_cell_colour;
    logic [7:0] next_base_x;
    logic [6:0] next_base_y;
    logic       clear_on_screen;
    logic       unused_bits;

    assign unused_bits = ^{gridCounter[15], pixelCount[15:7]};

    // Cell lookup for the box addressed by gridCounter row / boxCounter lane
    always_comb begin
        row_sel     = gridCounter[2:0];
        cell_bit    = grid[row_sel][boxCounter];
        lane_colour = 3'b010;
        case (boxCounter)
            2'd0: lane_colour = 3'b010;
            2'd1: lane_colour = 3'b100;
            2'd2: lane_colour = 3'b110;
            2'd3: lane_colour = 3'b001;
            default: lane_colour = 3'b010;
        endcase
`ifdef HIT_LINE_EN
        empty_colour = (row_sel == 3'(HIT_ROW)) ? 3'b111 : BG_COLOUR;
`else
        empty_colour = BG_COLOUR;
`endif
        next_cell_colour = cell_bit ? lane_colour : empty_colour;
        next_base_x      = 8'(LANE_X0) + {1'b0, boxCounter, 5'b0_0000};
        next_base_y      = {row_sel, 4'b0000};
        clear_on_screen  = (gridCounter[7:0] < 8'(SCREEN_W)) &&
                           (gridCounter[14:8] < 7'(SCREEN_H));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < int'(ROWS); r++) grid[r] <= '0;
            x              <= '0;
            y              <= '0;
            base_x         <= '0;
            base_y         <= '0;
            cell_colour    <= '0;
            cell_offscreen <= 1'b0;
            colour         <= '0;
            plot           <= 1'b0;
            hitRow         <= '0;
        end else begin
            // Scroll is independent of the draw strobes; a same-cycle load sees the pre-shift grid
            if (shiftSong) begin
                for (int r = int'(ROWS) - 1; r > 0; r--) grid[r] <= grid[r-1];
                grid[0] <= noteIn;
            end
            hitRow <= grid[HIT_ROW];
            plot   <= 1'b0;

            if (loadDefault) begin
                x      <= '0;
                y      <= '0;
                base_x <= '0;
                base_y <= '0;
                colour <= '0;
            end else if (writeDefault) begin
                x      <= gridCounter[7:0];
                y      <= gridCounter[14:8];
                colour <= BG_COLOUR;
                plot   <= clear_on_screen;
            end else if (loadStartAddress) begin
                base_x         <= next_base_x;
                base_y         <= next_base_y;
                cell_colour    <= next_cell_colour;
                cell_offscreen <= (row_sel == 3'(ROWS - 1));
            end else begin
                if (loadX) x <= base_x + {4'b0000, pixelCount[3:0]};
                if (loadY) y <= base_y + {4'b0000, pixelCount[6:4]};
                if (writeToScreen) begin
                    colour <= cell_colour;
                    plot   <= !cell_offscreen && (x < 8'(SCREEN_W));
                end
            end
        end
    end

endmodule

// File: doc/display_datapath.md
DISPLAY_DATAPATH -- requirements
Module: display_datapath

Interface
REQ-001 Parameter LANE_X0, default 24, x pixel of lane 0 box origin.
REQ-002 Parameter BG_COLOUR, default 3'b000, background colour used by screen clear and empty cells.
REQ-003 clock  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 loadDefault  input  1  clear draw registers.
REQ-006 writeDefault  input  1  screen-clear plot request for pixel addressed by gridCounter.
REQ-007 loadStartAddress  input  1  latch box origin and cell colour for gridCounter row, boxCounter lane.
REQ-008 loadX  input  1  latch x = box origin x + pixel offset.
REQ-009 loadY  input  1  latch y = box origin y + pixel offset.
REQ-010 writeToScreen  input  1  plot request for current box pixel.
REQ-011 shiftSong  input  1  advance note grid one row.
REQ-012 gridCounter  input  16  clear mode: [7:0]=x, [14:8]=y; shape mode: [2:0]=grid row.
REQ-013 boxCounter  input  2  lane index 0..3.
REQ-014 pixelCount  input  16  [3:0]=x offset, [6:4]=y offset inside 16x8 box; upper bits ignored.
REQ-015 noteIn  input  4  next song row from song ROM, bit n = note in lane n.
REQ-016 x  output  8  VGA adapter x.
REQ-017 y  output  7  VGA adapter y.
REQ-018 colour  output  3  VGA adapter colour.
REQ-019 plot  output  1  VGA adapter write enable.
REQ-020 hitRow  output  4  registered copy of grid row 6 (strum line).

Function
REQ-021 Note grid SHALL be 8 rows x 4 bits; on shiftSong row[r] <= row[r-1] for r=7..1, row[0] <= noteIn; row[7] content discarded next shift.
REQ-022 loadStartAddress SHALL latch baseX = LANE_X0 + 32*boxCounter (8-bit), baseY = 16*gridCounter[2:0] (7-bit, row 7 flagged off-screen), cellColour = lane colour if grid bit set else BG_COLOUR.
REQ-023 Lane colours SHALL be lane0 3'b010, lane1 3'b100, lane2 3'b110, lane3 3'b001.
REQ-024 shiftSong with loadStartAddress in same cycle: cell colour SHALL use pre-shift grid.
REQ-025 loadX SHALL set x <= baseX + pixelCount[3:0]; loadY SHALL set y <= baseY + pixelCount[6:4]; both in same cycle allowed.
REQ-026 writeDefault SHALL set x <= gridCounter[7:0], y <= gridCounter[14:8], colour <= BG_COLOUR, plot <= 1 in the next cycle iff x<160 and y<120, else 0.
REQ-027 writeToScreen SHALL set colour <= cellColour and plot <= 1 one cycle later, using x/y as loaded; plot <= 0 if latched row is 7 or x>=160.
REQ-028 plot SHALL be a one-cycle pulse per request; with no request in a cycle plot <= 0.
REQ-029 Priority in one cycle: loadDefault > writeDefault > loadStartAddress > loadX/loadY/writeToScreen; lower-priority draw strobes ignored that cycle; shiftSong always honoured.
REQ-030 loadDefault SHALL clear x, y, baseX, baseY, colour, plot to 0; grid unaffected.
REQ-031 hitRow SHALL update the cycle after grid row 6 changes.

Reset
REQ-032 reset SHALL clear grid, x, y, baseX, baseY, cellColour, colour, plot, hitRow to 0; reset mid-draw SHALL abort any pending plot (plot 0 next cycle).
REQ-033 reset SHALL take priority over all inputs.

Configuration
REQ-034 Macro HIT_LINE_EN: when defined, empty cells in grid row 6 SHALL draw colour 3'b111 (strum line highlight); when undefined they draw BG_COLOUR like other rows.

Verification
REQ-035 reset, then writeDefault with gridCounter=16'h7777 (x=119,y=119) -> next cycle x=119, y=119, colour=000, plot=1; gridCounter=16'h00A0 (x=160) -> plot=0.
REQ-036 noteIn=4'b0101, one shiftSong; loadStartAddress row0 lane2, loadX/loadY pixelCount=16'h0035, writeToScreen -> x=93, y=3, colour=110, plot=1 one cycle later.
REQ-037 Seven shiftSong with noteIn=4'b1000 then zeros -> hitRow=4'b1000 after 7th shift; 8th shift -> hitRow=0.
REQ-038 loadStartAddress row7 lane0, writeToScreen -> plot=0; with HIT_LINE_EN, empty row6 cell drawn -> colour=111.
REQ-039 loadDefault and writeToScreen same cycle -> plot=0, x=y=0; reset asserted cycle after writeToScreen -> plot=0.
